// File: rtl/ahb3lite_interconnect_switch_ctrl_if.sv
// Address-phase view of one master port plus the switch-control outputs
// that the slave-port arbiter samples.
interface ahb3lite_interconnect_switch_ctrl_if #(
    parameter int MAX_INCR_BEATS = 16,
    parameter int HOLD_BITS      = $clog2(MAX_INCR_BEATS + 1)
);
    logic                 HSEL;
    logic [1:0]           HTRANS;
    logic [2:0]           HBURST;
    logic                 HMASTLOCK;
    logic                 HREADY;
    logic                 other_req;

    logic                 can_switch;
    logic                 burst_active;
    logic [7:0]           beats_left;
    logic [HOLD_BITS-1:0] hold_cnt;
    logic                 incr_preempt;

    // Bus side: drives the observed master signals, reads the switch status.
    modport master (
        output HSEL, HTRANS, HBURST, HMASTLOCK, HREADY, other_req,
        input  can_switch, burst_active, beats_left, hold_cnt, incr_preempt
    );

    // Tracker side.
    modport slave (
        input  HSEL, HTRANS, HBURST, HMASTLOCK, HREADY, other_req,
        output can_switch, burst_active, beats_left, hold_cnt, incr_preempt
    );
endinterface

// File: rtl/ahb3lite_interconnect_switch_ctrl.sv
// Per-master burst/lock tracker: tells the slave-port arbiter when this master
// may be re-arbitrated without breaking a fixed burst or a locked sequence.
module ahb3lite_interconnect_switch_ctrl #(
    parameter int MAX_INCR_BEATS = 16,
    parameter int HOLD_BITS      = $clog2(MAX_INCR_BEATS + 1)
) (
    input  logic HCLK,
    input  logic HRESETn,
    ahb3lite_interconnect_switch_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_INCR  = 2'd2;
    localparam logic [1:0] S_LOCK  = 2'd3;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR   = 3'd1;

    localparam logic [HOLD_BITS-1:0] HOLD_MAX = HOLD_BITS'(MAX_INCR_BEATS);
    localparam logic [HOLD_BITS-1:0] HOLD_THR = HOLD_BITS'(MAX_INCR_BEATS - 1);

    logic [1:0]           state_q, state_d;
    logic [7:0]           beats_q, beats_d;
    logic [HOLD_BITS-1:0] hold_q, hold_d;

    logic       acc;
    logic       is_nonseq;
    logic       is_seq;
    logic       fixed_burst;
    logic [7:0] burst_len;
    logic       fresh_phase;
    logic       cs_raw;
    logic       preempt_raw;
    logic [7:0] beats_out;

    assign is_nonseq   = (bus.HTRANS == TR_NONSEQ);
    assign is_seq      = (bus.HTRANS == TR_SEQ);
    assign acc         = bus.HREADY & bus.HSEL & bus.HTRANS[1];
    assign fixed_burst = (bus.HBURST[2:1] != 2'b00);

    always_comb begin
        case (bus.HBURST[2:1])
            2'b01:   burst_len = 8'd4;
            2'b10:   burst_len = 8'd8;
            2'b11:   burst_len = 8'd16;
            default: burst_len = 8'd0;
        endcase
    end

    // A phase is judged "fresh" (with idle rules) whenever nothing in flight
    // constrains it: idle, an early-terminated burst, or a released lock.
    always_comb begin
        case (state_q)
            S_BURST, S_INCR: fresh_phase = (bus.HTRANS == TR_IDLE) || is_nonseq;
            S_LOCK:          fresh_phase = !bus.HMASTLOCK;
            default:         fresh_phase = 1'b1;
        endcase
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the branches below can leave one unassigned and infer a latch.
        state_d     = state_q;
        beats_d     = beats_q;
        hold_d      = hold_q;
        cs_raw      = 1'b0;
        preempt_raw = 1'b0;
        beats_out   = beats_q;

        if (fresh_phase) begin
            cs_raw    = !(is_nonseq && (bus.HBURST != HB_SINGLE));
            beats_out = (is_nonseq && fixed_burst && !bus.HMASTLOCK) ? burst_len : 8'd0;
            state_d   = S_IDLE;
            beats_d   = 8'd0;
            hold_d    = '0;
            if (acc && is_nonseq) begin
                if (fixed_burst) begin
                    state_d = S_BURST;
                    beats_d = burst_len - 8'd1;
                end else if (bus.HBURST == HB_INCR) begin
                    state_d = S_INCR;
                    hold_d  = HOLD_BITS'(1);
                end
            end
        end else begin
            case (state_q)
                S_BURST: begin
                    // Only the last beat's address phase opens the switch window.
                    cs_raw = is_seq && (beats_q == 8'd1);
                    if (acc && is_seq) begin
                        beats_d = beats_q - 8'd1;
                        if (beats_q == 8'd1) state_d = S_IDLE;
                    end
                end
                S_INCR: begin
                    preempt_raw = is_seq && bus.other_req && (hold_q >= HOLD_THR);
                    cs_raw      = preempt_raw;
                    if (preempt_raw) begin
                        state_d = S_IDLE;
                        hold_d  = '0;
                    end else if (acc && is_seq && (hold_q != HOLD_MAX)) begin
                        hold_d = hold_q + HOLD_BITS'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        // Lock overrides whatever burst tracking would otherwise decide.
        if (bus.HMASTLOCK) begin
            state_d = S_LOCK;
            beats_d = 8'd0;
            hold_d  = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            beats_q <= 8'd0;
            hold_q  <= '0;
        end else if (bus.HREADY) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            beats_q <= beats_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.can_switch   = cs_raw & ~bus.HMASTLOCK;
    assign bus.incr_preempt = preempt_raw & ~bus.HMASTLOCK;
    assign bus.burst_active = (state_q == S_BURST) || (state_q == S_INCR);
    assign bus.beats_left   = beats_out;
    assign bus.hold_cnt     = hold_q;
endmodule
